// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_WRITE,
    ST_DONE,
    ST_DZERO
  } md_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned ITER_DEFAULT = 32;
  localparam int unsigned CNT_W        = 6;

endpackage

// File: rtl/md_cycle_counter.sv
// Loadable down-counter; last flags the final iteration so the count never wraps.
module md_cycle_counter
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_sequencer.sv
// Sequences the iterative mult/div units and HI/LO writes for the multicycle MIPS core.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic abort,
  input  logic divzero_in,
  output logic mloadab,
  output logic mult,
  output logic dloadab,
  output logic div,
  output logic muxhigh,
  output logic muxlow,
  output logic highwrite,
  output logic lowwrite,
  output logic busy,
  output logic done,
  output logic divzero_exc
);

  localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(ITER);

  md_state_t state;
  logic      op_q;
  logic      cnt_load;
  logic      cnt_en;
  logic      cnt_last;

  assign cnt_load = (state == ST_LOAD);
  assign cnt_en   = (state == ST_CALC);

  md_cycle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (ITER_LOAD),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= OP_MULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if ((op_q == OP_DIV) && divzero_in) begin
            state <= ST_DZERO;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (cnt_last) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: state <= abort ? ST_IDLE : ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        ST_DZERO: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state; only the HI/LO write enables also see abort,
  // so an abort in WRITE blocks the write within the same cycle.
  always_comb begin
    mloadab     = 1'b0;
    mult        = 1'b0;
    dloadab     = 1'b0;
    div         = 1'b0;
    muxhigh     = 1'b0;
    muxlow      = 1'b0;
    highwrite   = 1'b0;
    lowwrite    = 1'b0;
    done        = 1'b0;
    divzero_exc = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_LOAD: begin
        mloadab = (op_q == OP_MULT);
        dloadab = (op_q == OP_DIV);
      end
      ST_CALC: begin
        mult = (op_q == OP_MULT);
        div  = (op_q == OP_DIV);
      end
      ST_WRITE: begin
        muxhigh   = op_q;
        muxlow    = op_q;
        highwrite = !abort;
        lowwrite  = !abort;
      end
      ST_DONE:  done        = 1'b1;
      ST_DZERO: divzero_exc = 1'b1;
      default: ;
    endcase
  end

endmodule
